// File: rtl/alu_writeback.sv
// ---------------------------------------------------------------------------
// alu_writeback
// Result-retire stage. Executed instructions arrive over a valid/ready
// handshake, are held in a small in-order buffer and retired one at a time:
// register-file write (when the instruction produces a result), SZCV flag
// update and a retired-instruction counter.
//
// Parameters
//   DEPTH  buffer entries (power of two, >= 2)
//   CNT_W  width of the retired-instruction counter
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready input handshake
//   in_ir             instruction: [15:14] op1, [13:11] Rs/Ra, [10:8] Rd/Rb, [7:4] op3
//   in_alu_out        ALU result
//   in_alu_flags      ALU flags {S,Z,C,V}
//   in_mem_data       load data (op1 = 00)
//   rf_we/rf_waddr/rf_wdata  register-file write request (registered)
//   rf_ready          register file accepts the write this cycle
//   flags             architectural SZCV register
//   retired           retired-instruction count (wraps)
//   halted            sticky halt indication
//
// Optional feature macro: ALU_WRITEBACK_HALT_EN
//   Defined   : retiring HLT (op1=11, op3=1111) halts the stage until reset.
//   Undefined : HLT retires as a no-write, no-flag instruction; halted = 0.
// ---------------------------------------------------------------------------
module alu_writeback #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_ir,
  input  logic [15:0]      in_alu_out,
  input  logic [3:0]       in_alu_flags,
  input  logic [15:0]      in_mem_data,
  output logic             rf_we,
  output logic [2:0]       rf_waddr,
  output logic [15:0]      rf_wdata,
  input  logic             rf_ready,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] retired,
  output logic             halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

`ifdef ALU_WRITEBACK_HALT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HALT = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;
`endif

  // Result-producing instructions: every load, and ALU ops except CMP/OUT/HLT/7/14.
  function automatic logic dec_write(input logic [1:0] op1, input logic [3:0] op3);
    logic w;
    w = 1'b0;
    case (op1)
      2'b00: w = 1'b1;
      2'b11: begin
        case (op3)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6,
          4'h8, 4'h9, 4'hA, 4'hB, 4'hC: w = 1'b1;
          default:                    w = 1'b0;
        endcase
      end
      default: w = 1'b0;
    endcase
    return w;
  endfunction

  // Flag-producing instructions: ALU ops 0-6 (CMP included) and 8-11.
  function automatic logic dec_flags(input logic [1:0] op1, input logic [3:0] op3);
    logic f;
    f = 1'b0;
    case (op1)
      2'b11: begin
        case (op3)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
          4'h8, 4'h9, 4'hA, 4'hB: f = 1'b1;
          default:              f = 1'b0;
        endcase
      end
      default: f = 1'b0;
    endcase
    return f;
  endfunction

  // Only ir[15:4] carries information for this stage.
  logic [11:0] ir_mem_r  [DEPTH];
  logic [15:0] alu_mem_r [DEPTH];
  logic [15:0] ld_mem_r  [DEPTH];
  logic [3:0]  fl_mem_r  [DEPTH];

  logic [AW-1:0]    head_r, tail_r, head_nxt_s;
  logic [CW-1:0]    count_r, count_nxt_s;
  state_t           state_r, state_nxt_s;
  logic             rf_we_r, rf_we_nxt_s;
  logic [2:0]       rf_waddr_r, waddr_nxt_s;
  logic [15:0]      rf_wdata_r, wdata_nxt_s;
  logic [3:0]       flags_r;
  logic [CNT_W-1:0] retired_r;
  logic             halted_s, halt_hit_s;
  logic             in_ready_s, push_s, pop_s, head_wr_s, take_in_s;
  logic [1:0]       h_op1_s;
  logic [3:0]       h_op3_s;
  logic [11:0]      n_ir_s;
  logic [15:0]      n_alu_s, n_ld_s;
  logic             unused_s;

  assign unused_s = ^in_ir[3:0];

  assign h_op1_s   = ir_mem_r[head_r][11:10];
  assign h_op3_s   = ir_mem_r[head_r][3:0];
  assign head_wr_s = dec_write(h_op1_s, h_op3_s);

`ifdef ALU_WRITEBACK_HALT_EN
  logic halted_r;
  assign halted_s   = halted_r;
  assign halt_hit_s = pop_s && (h_op1_s == 2'b11) && (h_op3_s == 4'hF);
`else
  assign halted_s   = 1'b0;
  assign halt_hit_s = 1'b0;
`endif

  assign in_ready_s = (count_r != CNT_FULL) && !halted_s;
  assign push_s     = in_valid && in_ready_s;

  // Retire condition: a writing head waits for rf_ready, others retire at once.
  always_comb begin
    pop_s = 1'b0;
    if (state_r == ST_BUSY) begin
      if (head_wr_s) begin
        pop_s = rf_ready;
      end else begin
        pop_s = 1'b1;
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // Occupancy and head pointer after this cycle.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    if (pop_s) begin
      head_nxt_s = head_r + AW'(1'b1);
    end else begin
      head_nxt_s = head_r;
    end
  end

  // The head of the next cycle: taken from the input when the buffer drains
  // to empty this cycle, so a freshly pushed entry drives rf_we one cycle later.
  always_comb begin
    take_in_s = (count_r == CNT_ZERO) || ((count_r == CNT_ONE) && pop_s);
    if (take_in_s) begin
      n_ir_s  = in_ir[15:4];
      n_alu_s = in_alu_out;
      n_ld_s  = in_mem_data;
    end else begin
      n_ir_s  = ir_mem_r[head_nxt_s];
      n_alu_s = alu_mem_r[head_nxt_s];
      n_ld_s  = ld_mem_r[head_nxt_s];
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (push_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (halt_hit_s) begin
`ifdef ALU_WRITEBACK_HALT_EN
          state_nxt_s = ST_HALT;
`else
          state_nxt_s = ST_BUSY;
`endif
        end else if (count_nxt_s == CNT_ZERO) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
`ifdef ALU_WRITEBACK_HALT_EN
      ST_HALT: state_nxt_s = ST_HALT;
`endif
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Write-port values for the next head; loads write Ra with memory data.
  always_comb begin
    rf_we_nxt_s = (state_nxt_s == ST_BUSY) && dec_write(n_ir_s[11:10], n_ir_s[3:0]);
    if (n_ir_s[11:10] == 2'b00) begin
      waddr_nxt_s = n_ir_s[9:7];
      wdata_nxt_s = n_ld_s;
    end else begin
      waddr_nxt_s = n_ir_s[6:4];
      wdata_nxt_s = n_alu_s;
    end
  end

  // Buffer pointers and occupancy; a halt flushes whatever is still buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= CNT_ZERO;
    end else if (halt_hit_s) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= CNT_ZERO;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + AW'(1'b1);
      end
      head_r  <= head_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Entry storage, written at the tail on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ir_mem_r[i]  <= 12'h000;
        alu_mem_r[i] <= 16'h0000;
        ld_mem_r[i]  <= 16'h0000;
        fl_mem_r[i]  <= 4'h0;
      end
    end else if (push_s) begin
      ir_mem_r[tail_r]  <= in_ir[15:4];
      alu_mem_r[tail_r] <= in_alu_out;
      ld_mem_r[tail_r]  <= in_mem_data;
      fl_mem_r[tail_r]  <= in_alu_flags;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered write port; address/data only reload for a writing head so
  // they stay stable while rf_ready is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= 3'd0;
      rf_wdata_r <= 16'h0000;
    end else begin
      rf_we_r <= rf_we_nxt_s;
      if (rf_we_nxt_s) begin
        rf_waddr_r <= waddr_nxt_s;
        rf_wdata_r <= wdata_nxt_s;
      end
    end
  end

  // Architectural flags and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r   <= 4'h0;
      retired_r <= {CNT_W{1'b0}};
    end else if (pop_s) begin
      retired_r <= retired_r + CNT_W'(1'b1);
      if (dec_flags(h_op1_s, h_op3_s)) begin
        flags_r <= fl_mem_r[head_r];
      end
    end
  end

`ifdef ALU_WRITEBACK_HALT_EN
  // Sticky halt, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_r <= 1'b0;
    end else if (halt_hit_s) begin
      halted_r <= 1'b1;
    end
  end
`endif

  assign in_ready = in_ready_s;
  assign rf_we    = rf_we_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = rf_wdata_r;
  assign flags    = flags_r;
  assign retired  = retired_r;
  assign halted   = halted_s;

endmodule

// File: tb/tb_alu_writeback.sv
// ---------------------------------------------------------------------------
// tb_alu_writeback
// Self-checking bench for alu_writeback: a table of single-instruction
// vectors, hand-written multi-cycle sequences (write stall, buffer fill,
// reset mid-operation, HLT handling) and a randomized run checked against an
// in-order retirement model built from the instruction-set rules.
// ---------------------------------------------------------------------------
module tb_alu_writeback;

  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_ir;
  logic [15:0]      in_alu_out;
  logic [3:0]       in_alu_flags;
  logic [15:0]      in_mem_data;
  logic             rf_we;
  logic [2:0]       rf_waddr;
  logic [15:0]      rf_wdata;
  logic             rf_ready;
  logic [3:0]       flags;
  logic [CNT_W-1:0] retired;
  logic             halted;

  alu_writeback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ir        (in_ir),
    .in_alu_out   (in_alu_out),
    .in_alu_flags (in_alu_flags),
    .in_mem_data  (in_mem_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .rf_ready     (rf_ready),
    .flags        (flags),
    .retired      (retired),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] alu;
    logic [3:0]  fl;
    logic [15:0] mem;
    logic        we;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [3:0]  exp_flags;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ret = 0;

  // Reference model state for the randomized run.
  logic [15:0] m_ir[$];
  logic [15:0] m_alu[$];
  logic [15:0] m_mem[$];
  logic [3:0]  m_fh[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Instruction-set rules, stated as sets of opcodes.
  function automatic logic m_writes(input logic [15:0] ir);
    return (ir[15:14] == 2'b00) ||
           (ir[15:14] == 2'b11 && (ir[7:4] inside {[4'd0:4'd4], 4'd6, [4'd8:4'd12]}));
  endfunction

  function automatic logic m_sets_flags(input logic [15:0] ir);
    return (ir[15:14] == 2'b11) && (ir[7:4] inside {[4'd0:4'd6], [4'd8:4'd11]});
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] ir, input logic [15:0] alu,
                       input logic [3:0] fl, input logic [15:0] mem);
    in_valid     = 1'b1;
    in_ir        = ir;
    in_alu_out   = alu;
    in_alu_flags = fl;
    in_mem_data  = mem;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rf_ready = 1'b0;
    rst_n    = 1'b0;
    step();
    step();
    rst_n   = 1'b1;
    exp_ret = 0;
    step();
  endtask

  vec_t vecs[12];

  initial begin
    logic [3:0]  prev_flags;
    logic [15:0] rir;
    logic        ew;
    int          r, a;

    vecs[0]  = '{16'hC300, 16'h1234, 4'b0100, 16'h0000, 1'b1, 3'd3, 16'h1234, 4'b0100}; // ADD r3
    vecs[1]  = '{16'hC350, 16'h9999, 4'b0010, 16'h0000, 1'b0, 3'd0, 16'h0000, 4'b0010}; // CMP
    vecs[2]  = '{16'h2800, 16'h1111, 4'b1111, 16'hBEEF, 1'b1, 3'd5, 16'hBEEF, 4'b0010}; // LD Ra=5
    vecs[3]  = '{16'h4000, 16'h2222, 4'b1000, 16'h3333, 1'b0, 3'd0, 16'h0000, 4'b0010}; // ST
    vecs[4]  = '{16'h8000, 16'h4444, 4'b1000, 16'h5555, 1'b0, 3'd0, 16'h0000, 4'b0010}; // branch
    vecs[5]  = '{16'hC0D0, 16'h6666, 4'b0001, 16'h0000, 1'b0, 3'd0, 16'h0000, 4'b0010}; // OUT
    vecs[6]  = '{16'hC6C0, 16'hABCD, 4'b1001, 16'h0000, 1'b1, 3'd6, 16'hABCD, 4'b0010}; // op3=12: write, no flags
    vecs[7]  = '{16'hC760, 16'h5555, 4'b1001, 16'h0000, 1'b1, 3'd7, 16'h5555, 4'b1001}; // op3=6
    vecs[8]  = '{16'hC170, 16'h7777, 4'b0110, 16'h0000, 1'b0, 3'd0, 16'h0000, 4'b1001}; // op3=7: nothing
    vecs[9]  = '{16'hC2B0, 16'h00FF, 4'b0110, 16'h0000, 1'b1, 3'd2, 16'h00FF, 4'b0110}; // op3=11
    vecs[10] = '{16'hC4E0, 16'h8888, 4'b1111, 16'h0000, 1'b0, 3'd0, 16'h0000, 4'b0110}; // op3=14
    vecs[11] = '{16'hC140, 16'h0F0F, 4'b1100, 16'h0000, 1'b1, 3'd1, 16'h0F0F, 4'b1100}; // op3=4

    in_ir = 16'h0000; in_alu_out = 16'h0000; in_alu_flags = 4'h0; in_mem_data = 16'h0000;
    @(negedge clk);
    do_reset();

    // Reset state.
    chk("reset rf_we",    32'(rf_we),    32'd0);
    chk("reset rf_waddr", 32'(rf_waddr), 32'd0);
    chk("reset rf_wdata", 32'(rf_wdata), 32'd0);
    chk("reset flags",    32'(flags),    32'd0);
    chk("reset retired",  32'(retired),  32'd0);
    chk("reset halted",   32'(halted),   32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    // Table of single instructions with rf_ready high.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].ir, vecs[i].alu, vecs[i].fl, vecs[i].mem);
      rf_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d rf_we", i), 32'(rf_we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("vec%0d rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].addr));
        chk($sformatf("vec%0d rf_wdata", i), 32'(rf_wdata), 32'(vecs[i].data));
      end
      step();
      exp_ret++;
      chk($sformatf("vec%0d flags", i),   32'(flags),   32'(vecs[i].exp_flags));
      chk($sformatf("vec%0d retired", i), 32'(retired), 32'(exp_ret));
      chk($sformatf("vec%0d idle we", i), 32'(rf_we),   32'd0);
    end
    prev_flags = 4'b1100;

    // Load with the register file stalled for three cycles.
    drive(16'h2800, 16'h0000, 4'b1111, 16'hBEEF);
    rf_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d rf_we", i),    32'(rf_we),    32'd1);
      chk($sformatf("stall%0d rf_waddr", i), 32'(rf_waddr), 32'd5);
      chk($sformatf("stall%0d rf_wdata", i), 32'(rf_wdata), 32'hBEEF);
      chk($sformatf("stall%0d retired", i),  32'(retired),  32'(exp_ret));
      step();
    end
    chk("stall held we", 32'(rf_we), 32'd1);
    rf_ready = 1'b1;
    step();
    exp_ret++;
    chk("stall retire we",  32'(rf_we),   32'd0);
    chk("stall retired",    32'(retired), 32'(exp_ret));
    chk("stall flags kept", 32'(flags),   32'(prev_flags));

    // Fill the buffer with the register file stalled, then drain.
    rf_ready = 1'b0;
    drive(16'hC100, 16'hA001, 4'b0001, 16'h0000);
    step();
    chk("fill ready1", 32'(in_ready), 32'd1);
    chk("fill addrA",  32'(rf_waddr), 32'd1);
    drive(16'hC200, 16'hA002, 4'b0010, 16'h0000);
    step();
    chk("fill ready2", 32'(in_ready), 32'd0);
    drive(16'hC300, 16'hA003, 4'b0100, 16'h0000);
    step();
    chk("fill full",   32'(in_ready), 32'd0);
    chk("fill holdA",  32'(rf_wdata), 32'hA001);
    rf_ready = 1'b1;
    step();
    chk("fill addrB",  32'(rf_waddr), 32'd2);
    chk("fill dataB",  32'(rf_wdata), 32'hA002);
    chk("fill ready3", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("fill addrC",  32'(rf_waddr), 32'd3);
    chk("fill dataC",  32'(rf_wdata), 32'hA003);
    chk("fill weC",    32'(rf_we),    32'd1);
    step();
    exp_ret += 3;
    chk("fill drained we", 32'(rf_we),    32'd0);
    chk("fill retired",    32'(retired),  32'(exp_ret));
    chk("fill flags",      32'(flags),    32'b0100);
    chk("fill ready4",     32'(in_ready), 32'd1);

    // Reset while a write is pending with two entries buffered.
    rf_ready = 1'b0;
    drive(16'hC500, 16'h5A5A, 4'b1010, 16'h0000);
    step();
    drive(16'hC600, 16'h6B6B, 4'b1011, 16'h0000);
    step();
    in_valid = 1'b0;
    chk("pre-reset we",    32'(rf_we),    32'd1);
    chk("pre-reset ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset we", 32'(rf_we), 32'd0);
    step();
    rst_n   = 1'b1;
    exp_ret = 0;
    step();
    chk("post-reset flags",   32'(flags),    32'd0);
    chk("post-reset retired", 32'(retired),  32'd0);
    chk("post-reset ready",   32'(in_ready), 32'd1);
    chk("post-reset we",      32'(rf_we),    32'd0);

    // HLT followed by ADD.
    rf_ready = 1'b1;
    drive(16'hC0F0, 16'h0000, 4'b1111, 16'h0000);
    step();
    drive(16'hC300, 16'h7777, 4'b0011, 16'h0000);
    step();
`ifdef ALU_WRITEBACK_HALT_EN
    exp_ret++;
    chk("halt halted",  32'(halted),   32'd1);
    chk("halt ready",   32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("halt%0d we", i), 32'(rf_we), 32'd0);
      step();
    end
    in_valid = 1'b0;
    chk("halt retired", 32'(retired), 32'(exp_ret));
    chk("halt sticky",  32'(halted),  32'd1);
    chk("halt ready2",  32'(in_ready), 32'd0);
    chk("halt flags",   32'(flags),   32'd0);
`else
    in_valid = 1'b0;
    chk("hlt halted", 32'(halted),   32'd0);
    chk("hlt add we", 32'(rf_we),    32'd1);
    chk("hlt add rd", 32'(rf_waddr), 32'd3);
    chk("hlt add wd", 32'(rf_wdata), 32'h7777);
    step();
    exp_ret += 2;
    chk("hlt retired", 32'(retired), 32'(exp_ret));
    chk("hlt flags",   32'(flags),   32'b0011);
`endif

    // Randomized traffic checked against the in-order retirement model.
    do_reset();
    m_ir.delete(); m_alu.delete(); m_mem.delete(); m_fh.delete();
    m_fh.push_back(4'h0);
    for (int c = 0; c < 3000; c++) begin
      r = int'(retired);
      a = m_ir.size();
      if (r > a) begin
        chk("rand retired<=accepted", 32'(r), 32'(a));
        break;
      end
      chk("rand in_ready", 32'(in_ready), 32'((a - r) != DEPTH));
      chk("rand flags",    32'(flags),    32'(m_fh[r]));
      ew = (a > r) ? m_writes(m_ir[r]) : 1'b0;
      chk("rand rf_we",    32'(rf_we),    32'(ew));
      if (ew && rf_we) begin
        chk("rand rf_waddr", 32'(rf_waddr),
            32'((m_ir[r][15:14] == 2'b00) ? m_ir[r][13:11] : m_ir[r][10:8]));
        chk("rand rf_wdata", 32'(rf_wdata),
            32'((m_ir[r][15:14] == 2'b00) ? m_mem[r] : m_alu[r]));
      end
      rir = 16'($urandom);
`ifdef ALU_WRITEBACK_HALT_EN
      if (rir[15:14] == 2'b11 && rir[7:4] == 4'hF) begin
        rir[7:4] = 4'hD;
      end
`endif
      drive(rir, 16'($urandom), 4'($urandom), 16'($urandom));
      in_valid = ($urandom_range(0, 9) < 7);
      rf_ready = ($urandom_range(0, 9) < 6);
      if (in_valid && in_ready) begin
        m_ir.push_back(in_ir);
        m_alu.push_back(in_alu_out);
        m_mem.push_back(in_mem_data);
        m_fh.push_back(m_sets_flags(in_ir) ? in_alu_flags : m_fh[m_fh.size() - 1]);
      end
      step();
    end
    in_valid = 1'b0;
    rf_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (int'(retired) == m_ir.size()) break;
      step();
    end
    chk("rand drain retired", 32'(retired), 32'(m_ir.size()));
    chk("rand drain flags",   32'(flags),   32'(m_fh[m_fh.size() - 1]));
    chk("rand drain we",      32'(rf_we),   32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Result-retire stage on the consuming side of the ALU/operand path.
- Accepts one executed instruction per valid/ready handshake: instruction word, ALU result, ALU flags and load data.
- Buffers up to DEPTH entries and retires them in order.
- On retire: drives the register-file write port, updates the architectural SZCV flag register and counts retired instructions.

Parameters:
- DEPTH, 2, buffer entries (power of two, >= 2).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  executed instruction offered.
- in_ready  output  1  buffer can accept this cycle.
- in_ir  input  16  instruction word: [15:14] op1, [13:11] Rs/Ra, [10:8] Rd/Rb, [7:4] op3.
- in_alu_out  input  16  ALU result.
- in_alu_flags  input  4  ALU flags {S,Z,C,V}.
- in_mem_data  input  16  load data, used only for op1=00.
- rf_we  output  1  register-file write request.
- rf_waddr  output  3  destination register.
- rf_wdata  output  16  write data.
- rf_ready  input  1  register file accepts write this cycle.
- flags  output  4  architectural SZCV register.
- retired  output  CNT_W  retired-instruction count.
- halted  output  1  sticky halt; tied 0 when feature is off.

Behaviour:
- Reset values (asynchronous assert, synchronous release): buffer empty, rf_we=0, rf_waddr=0, rf_wdata=0, flags=0000, retired=0, halted=0, FSM=IDLE.
- Buffer:
  - in_ready = (count != DEPTH) && !halted.
  - Push when in_valid && in_ready.
  - Head and tail pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - A push when full is impossible because in_ready=0.
- Decode of the head entry:
  - op1=11, op3 in {0000-0100, 0110, 1000-1011, 1100}: write in_alu_out to Rd.
  - op1=11, op3 in {0101 CMP, 1101 OUT, 1111 HLT, others}: no write.
  - op1=00 (LD): write in_mem_data to Ra = ir[13:11].
  - op1=01 (ST) and op1=10 (branch): no write.
  - Flag update: only op1=11 with op3 in {0000-0110, 1000-1011}; flags <= head alu_flags at retire.
- FSM states:
  - IDLE: buffer empty, rf_we=0. Goes to BUSY the cycle after the first push.
  - BUSY:
    - Head needs a write: rf_we=1 with rf_waddr/rf_wdata registered from the head. Retire occurs in the cycle rf_ready=1. While rf_ready=0, hold rf_we, rf_waddr and rf_wdata stable.
    - Head needs no write: rf_we=0, retire in one cycle.
    - After retire: stay in BUSY if entries remain (including a same-cycle push), else go to IDLE.
  - HALT: only exists with the optional feature.
- Latency: entry pushed in cycle N produces rf_we at N+1 at the earliest. Back-to-back retires run at 1 per cycle when rf_ready stays high.
- Retire effects: retired increments by 1 and wraps from 2^CNT_W-1 to 0. Flags change in the same cycle as the retire and are visible the next cycle.
- Reset mid-operation: buffered entries are discarded; rf_we drops immediately (asynchronously).

Optional Feature:
- Macro: ALU_WRITEBACK_HALT_EN.
- Defined:
  - Retiring op1=11/op3=1111 sets halted=1 and the FSM enters HALT.
  - In HALT, in_ready=0 and rf_we=0; remaining buffered entries are flushed.
  - HALT is exited only by reset.
- Undefined: HLT retires as a plain no-write, no-flag instruction; halted is constant 0; the HALT state is absent.

Test Plan:
- ADD r3, ir=16'hC300 (op3=0000), alu_out=16'h1234, flags=0100, rf_ready=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=16'h1234; then flags=0100 and retired=1.
- CMP, ir=16'hC350, flags=0010 -> rf_we never asserted; flags=0010; retired increments.
- LD, ir=16'h2800 (Ra=5), mem_data=16'hBEEF, rf_ready=0 for 3 cycles -> rf_we/addr=5/data=BEEF held stable for 3 cycles; retire on the 4th; flags unchanged.
- DEPTH=2 fill: push 3 back-to-back with rf_ready=0 -> in_ready=0 after 2 pushes; raise rf_ready -> in order retire, 1 per cycle, in_ready returns high.
- Reset: assert rst_n=0 while rf_we=1 with 2 entries buffered -> rf_we=0 immediately; after release flags=0, retired=0, in_ready=1.
- ALU_WRITEBACK_HALT_EN: HLT (16'hC0F0) followed by ADD -> halted=1 after the HLT retires; ADD never written; in_ready stays 0.
